tcdm_lat_xbar: RTL and testbench

TCDM_LAT_XBAR -- requirements
Module: tcdm_lat_xbar

---
 rtl/tcdm_xbar_pkg.sv | 18 +
 rtl/tcdm_lat_xbar_if.sv | 38 +++
 rtl/tcdm_rr_arb.sv | 49 ++++
 rtl/tcdm_lat_xbar.sv | 159 +++++++++++++++
 tb/tb_tcdm_lat_xbar.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/tcdm_xbar_pkg.sv
// Shared constants, word-offset helper and response-pipeline entry for the TCDM crossbar.
// Pure definitions: no latency, no backpressure.
package tcdm_xbar_pkg;

   localparam int unsigned MemLatMin  = 1;
   localparam int unsigned MemLatMax  = 4;
   localparam int unsigned MasterIdxW = 8;

   typedef struct packed {
      logic                  valid;
      logic [MasterIdxW-1:0] idx;
   } resp_t;

   function automatic int unsigned word_off(input int unsigned data_width);
      return $clog2(data_width / 8);
   endfunction

endpackage

// File: rtl/tcdm_lat_xbar_if.sv
// Initiator- and bank-side signal bundle of the TCDM crossbar; slave = crossbar view, master = initiator/bank-model view.
// Wires only: no latency, no backpressure.
interface tcdm_lat_xbar_if #(
   parameter int unsigned NumMaster    = 8,
   parameter int unsigned NumSlave     = 16,
   parameter int unsigned AddrWidth    = 32,
   parameter int unsigned DataWidth    = 32,
   parameter int unsigned BeWidth      = DataWidth / 8,
   parameter int unsigned AddrMemWidth = 12
) ();

   logic [NumMaster-1:0]                    req_i;
   logic [NumMaster-1:0][AddrWidth-1:0]     add_i;
   logic [NumMaster-1:0]                    wen_i;
   logic [NumMaster-1:0][DataWidth-1:0]     wdata_i;
   logic [NumMaster-1:0][BeWidth-1:0]       be_i;
   logic [NumMaster-1:0]                    gnt_o;
   logic [NumMaster-1:0]                    rvld_o;
   logic [NumMaster-1:0][DataWidth-1:0]     rdata_o;

   logic [NumSlave-1:0]                     cs_o;
   logic [NumSlave-1:0][AddrMemWidth-1:0]   add_o;
   logic [NumSlave-1:0]                     wen_o;
   logic [NumSlave-1:0][DataWidth-1:0]      wdata_o;
   logic [NumSlave-1:0][BeWidth-1:0]        be_o;
   logic [NumSlave-1:0][DataWidth-1:0]      rdata_i;

   modport slave (
      input  req_i, add_i, wen_i, wdata_i, be_i, rdata_i,
      output gnt_o, rvld_o, rdata_o, cs_o, add_o, wen_o, wdata_o, be_o
   );

   modport master (
      output req_i, add_i, wen_i, wdata_i, be_i, rdata_i,
      input  gnt_o, rvld_o, rdata_o, cs_o, add_o, wen_o, wdata_o, be_o
   );

endinterface

// File: rtl/tcdm_rr_arb.sv
// Per-bank round-robin arbiter: combinational grant, pointer moves past the winner on each grant.
// Zero-cycle latency; losers simply see no grant and keep requesting.
module tcdm_rr_arb #(
   parameter int unsigned NumMaster = 8,
   parameter int unsigned IdxW      = $clog2(NumMaster)
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic [NumMaster-1:0] req_i,
   output logic [NumMaster-1:0] gnt_o,
   output logic                 vld_o,
   output logic [IdxW-1:0]      idx_o
);

   localparam int unsigned SumW = IdxW + 1;

   logic [IdxW-1:0] rr_q;
   logic [SumW-1:0] cand;

   // Scan from the pointer upward, wrapping modulo NumMaster (not necessarily a power of two).
   always_comb begin
      gnt_o = '0;
      vld_o = 1'b0;
      idx_o = '0;
      cand  = '0;
      for (int i = 0; i < NumMaster; i++) begin
         cand = {1'b0, rr_q} + SumW'(i);
         if (cand >= SumW'(NumMaster)) begin
            cand = cand - SumW'(NumMaster);
         end
         if (!vld_o && req_i[cand[IdxW-1:0]]) begin
            vld_o = 1'b1;
            idx_o = cand[IdxW-1:0];
         end
      end
      if (vld_o) begin
         gnt_o[idx_o] = 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rr_q <= '0;
      end else if (vld_o) begin
         rr_q <= (idx_o == IdxW'(NumMaster - 1)) ? '0 : idx_o + IdxW'(1);
      end
   end

endmodule

// File: rtl/tcdm_lat_xbar.sv
// Fixed-latency TCDM crossbar: NumMaster initiators to NumSlave word-interleaved banks, grant same cycle, rvld_o MemLat cycles later
// (MemLat+1 and registered bank side with TCDM_XBAR_REQ_REG_EN); no backpressure beyond holding req_i until gnt_o.
module tcdm_lat_xbar
   import tcdm_xbar_pkg::*;
#(
   parameter int unsigned NumMaster    = 8,
   parameter int unsigned NumSlave     = 16,
   parameter int unsigned AddrWidth    = 32,
   parameter int unsigned DataWidth    = 32,
   parameter int unsigned BeWidth      = DataWidth / 8,
   parameter int unsigned AddrMemWidth = 12,
   parameter int unsigned MemLat       = 1
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   tcdm_lat_xbar_if.slave   bus
);

   localparam int unsigned WordOff = word_off(DataWidth);
   localparam int unsigned BankW   = $clog2(NumSlave);
   localparam int unsigned IdxW    = $clog2(NumMaster);
`ifdef TCDM_XBAR_REQ_REG_EN
   localparam int unsigned PipeDepth = MemLat + 1;
`else
   localparam int unsigned PipeDepth = MemLat;
`endif

   typedef struct packed {
      logic [AddrMemWidth-1:0] add;
      logic                    wen;
      logic [DataWidth-1:0]    wdata;
      logic [BeWidth-1:0]      be;
   } bank_req_t;

   logic      [NumSlave-1:0][NumMaster-1:0] bank_req;
   logic      [NumSlave-1:0][NumMaster-1:0] bank_gnt;
   logic      [NumSlave-1:0]                bank_vld;
   logic      [NumSlave-1:0][IdxW-1:0]      bank_idx;
   bank_req_t [NumSlave-1:0]                bank_dat;
   logic      [NumSlave-1:0]                out_cs;
   bank_req_t [NumSlave-1:0]                out_dat;
   resp_t     [NumSlave-1:0][PipeDepth-1:0] pipe_q;

   always_comb begin
      for (int k = 0; k < NumSlave; k++) begin
         for (int j = 0; j < NumMaster; j++) begin
            bank_req[k][j] = bus.req_i[j] && (bus.add_i[j][WordOff +: BankW] == BankW'(k));
         end
      end
   end

   for (genvar k = 0; k < NumSlave; k++) begin : g_bank
      tcdm_rr_arb #(
         .NumMaster (NumMaster)
      ) i_arb (
         .clk_i  (clk_i),
         .rst_ni (rst_ni),
         .req_i  (bank_req[k]),
         .gnt_o  (bank_gnt[k]),
         .vld_o  (bank_vld[k]),
         .idx_o  (bank_idx[k])
      );
   end

   // Each master decodes to exactly one bank, so OR-ing bank grants cannot double-grant.
   always_comb begin
      bus.gnt_o = '0;
      for (int k = 0; k < NumSlave; k++) begin
         bus.gnt_o = bus.gnt_o | bank_gnt[k];
      end
   end

   always_comb begin
      for (int k = 0; k < NumSlave; k++) begin
         bank_dat[k] = '0;
         if (bank_vld[k]) begin
            bank_dat[k].add   = bus.add_i[bank_idx[k]][WordOff+BankW +: AddrMemWidth];
            bank_dat[k].wen   = bus.wen_i[bank_idx[k]];
            bank_dat[k].wdata = bus.wdata_i[bank_idx[k]];
            bank_dat[k].be    = bus.be_i[bank_idx[k]];
         end
      end
   end

`ifdef TCDM_XBAR_REQ_REG_EN
   logic      [NumSlave-1:0] cs_q;
   bank_req_t [NumSlave-1:0] dat_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cs_q  <= '0;
         dat_q <= '0;
      end else begin
         cs_q  <= bank_vld;
         dat_q <= bank_dat;
      end
   end

   assign out_cs  = cs_q;
   assign out_dat = dat_q;
`else
   assign out_cs  = bank_vld;
   assign out_dat = bank_dat;
`endif

   always_comb begin
      for (int k = 0; k < NumSlave; k++) begin
         bus.cs_o[k]    = out_cs[k];
         bus.add_o[k]   = out_dat[k].add;
         bus.wen_o[k]   = out_dat[k].wen;
         bus.wdata_o[k] = out_dat[k].wdata;
         bus.be_o[k]    = out_dat[k].be;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pipe_q <= '0;
      end else begin
         for (int k = 0; k < NumSlave; k++) begin
            pipe_q[k][0].valid <= bank_vld[k];
            pipe_q[k][0].idx   <= MasterIdxW'(bank_idx[k]);
            for (int s = 1; s < PipeDepth; s++) begin
               pipe_q[k][s] <= pipe_q[k][s-1];
            end
         end
      end
   end

   // Fixed latency plus one grant per master per cycle means at most one bank matches each master here.
   always_comb begin
      bus.rvld_o  = '0;
      bus.rdata_o = '0;
      for (int j = 0; j < NumMaster; j++) begin
         for (int k = 0; k < NumSlave; k++) begin
            if (pipe_q[k][PipeDepth-1].valid && (pipe_q[k][PipeDepth-1].idx == MasterIdxW'(j))) begin
               bus.rvld_o[j]  = 1'b1;
               bus.rdata_o[j] = bus.rdata_o[j] | bus.rdata_i[k];
            end
         end
      end
   end

`ifndef SYNTHESIS
   if ((2 ** BankW) != NumSlave) begin : g_bad_num_slave
      $error("NumSlave must be a power of two");
   end
   if ((MemLat < MemLatMin) || (MemLat > MemLatMax)) begin : g_bad_mem_lat
      $error("MemLat out of range 1..4");
   end
   if ((WordOff + BankW + AddrMemWidth) > AddrWidth) begin : g_bad_addr
      $error("WordOff + log2(NumSlave) + AddrMemWidth exceeds AddrWidth");
   end
   if (NumMaster > (2 ** MasterIdxW)) begin : g_bad_num_master
      $error("NumMaster exceeds response index width");
   end
`endif

endmodule

// File: tb/tb_tcdm_lat_xbar.sv
// Directed bench for tcdm_lat_xbar with 4 masters, 8 banks, 32-bit words, MemLat=2.
module tb_tcdm_lat_xbar;

   localparam int unsigned NM  = 4;
   localparam int unsigned NS  = 8;
   localparam int unsigned AW  = 32;
   localparam int unsigned DW  = 32;
   localparam int unsigned BW  = 4;
   localparam int unsigned AMW = 12;
   localparam int unsigned ML  = 2;
`ifdef TCDM_XBAR_REQ_REG_EN
   localparam int Lat = ML + 1;
`else
   localparam int Lat = ML;
`endif

   logic clk_i  = 1'b0;
   logic rst_ni = 1'b0;
   int   checks   = 0;
   int   failures = 0;

   always #5 clk_i = ~clk_i;

   tcdm_lat_xbar_if #(
      .NumMaster (NM), .NumSlave (NS), .AddrWidth (AW),
      .DataWidth (DW), .BeWidth (BW), .AddrMemWidth (AMW)
   ) bus ();

   tcdm_lat_xbar #(
      .NumMaster (NM), .NumSlave (NS), .AddrWidth (AW), .DataWidth (DW),
      .BeWidth (BW), .AddrMemWidth (AMW), .MemLat (ML)
   ) dut (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .bus    (bus)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   function automatic logic [31:0] bank_word(input int k);
      return 32'hC0DE_0000 | (32'(k) * 32'h0101);
   endfunction

   task automatic idle();
      bus.req_i   = '0;
      bus.add_i   = '0;
      bus.wen_i   = '0;
      bus.wdata_i = '0;
      bus.be_i    = '0;
   endtask

   task automatic set_req(input int j, input logic [31:0] a, input logic wen,
                          input logic [31:0] wd, input logic [3:0] be);
      bus.req_i[j]   = 1'b1;
      bus.add_i[j]   = a;
      bus.wen_i[j]   = wen;
      bus.wdata_i[j] = wd;
      bus.be_i[j]    = be;
   endtask

   initial begin
      idle();
      for (int k = 0; k < NS; k++) bus.rdata_i[k] = bank_word(k);

      // Reset state, no requests
      @(negedge clk_i);
      chk("rst_gnt", 64'(bus.gnt_o), 64'h0);
      chk("rst_cs", 64'(bus.cs_o), 64'h0);
      chk("rst_rvld", 64'(bus.rvld_o), 64'h0);
      chk("rst_rdata", 64'(bus.rdata_o), 64'h0);
      tick();
      rst_ni = 1'b1;

      // Single load, master 0 -> bank 5, word 0
      set_req(0, 32'h0000_0014, 1'b1, 32'h0, 4'hF);
      @(negedge clk_i);
      chk("t1_gnt", 64'(bus.gnt_o), 64'h1);
`ifndef TCDM_XBAR_REQ_REG_EN
      chk("t1_cs", 64'(bus.cs_o), 64'h20);
      chk("t1_add", 64'(bus.add_o[5]), 64'h0);
      chk("t1_wen", 64'(bus.wen_o[5]), 64'h1);
`endif
      tick();
      idle();
      for (int c = 1; c < Lat; c++) begin
         @(negedge clk_i);
         chk("t1_rvld_early", 64'(bus.rvld_o), 64'h0);
         chk("t1_rdata_zero", 64'(bus.rdata_o[0]), 64'h0);
`ifdef TCDM_XBAR_REQ_REG_EN
         if (c == 1) chk("t1_cs_reg", 64'(bus.cs_o), 64'h20);
`endif
         tick();
      end
      @(negedge clk_i);
      chk("t1_rvld", 64'(bus.rvld_o), 64'h1);
      chk("t1_rdata", 64'(bus.rdata_o[0]), 64'(bank_word(5)));
      tick();
      @(negedge clk_i);
      chk("t1_rvld_drop", 64'(bus.rvld_o), 64'h0);
      tick();

      // All four masters contend for bank 2 for eight cycles
      for (int j = 0; j < NM; j++) set_req(j, (32'(j + 1) << 5) | 32'h8, 1'b1, 32'h0, 4'hF);
      for (int c = 0; c < 8; c++) begin
         @(negedge clk_i);
         chk($sformatf("t2_gnt_%0d", c), 64'(bus.gnt_o), 64'(4'b0001 << (c % 4)));
`ifndef TCDM_XBAR_REQ_REG_EN
         chk($sformatf("t2_add_%0d", c), 64'(bus.add_o[2]), 64'((c % 4) + 1));
`endif
         tick();
      end
      idle();
      repeat (Lat + 1) tick();

      // Masters 0..3 hit banks 0..3 in parallel
      for (int j = 0; j < NM; j++) set_req(j, (32'(j) << 2) | (32'(16 + j) << 5), 1'b1, 32'h0, 4'hF);
      @(negedge clk_i);
      chk("t3_gnt", 64'(bus.gnt_o), 64'hF);
`ifndef TCDM_XBAR_REQ_REG_EN
      chk("t3_cs", 64'(bus.cs_o), 64'h0F);
      for (int j = 0; j < NM; j++) chk($sformatf("t3_add_%0d", j), 64'(bus.add_o[j]), 64'(16 + j));
`endif
      tick();
      idle();
      repeat (Lat - 1) tick();
      @(negedge clk_i);
      chk("t3_rvld", 64'(bus.rvld_o), 64'hF);
      for (int j = 0; j < NM; j++) chk($sformatf("t3_rdata_%0d", j), 64'(bus.rdata_o[j]), 64'(bank_word(j)));
      tick();

      // Masked store from master 1 to bank 7, word 3
      set_req(1, 32'h0000_007C, 1'b0, 32'hDEAD_BEEF, 4'b0101);
      @(negedge clk_i);
      chk("t4_gnt", 64'(bus.gnt_o), 64'h2);
`ifndef TCDM_XBAR_REQ_REG_EN
      chk("t4_cs", 64'(bus.cs_o), 64'h80);
      chk("t4_wen", 64'(bus.wen_o[7]), 64'h0);
      chk("t4_be", 64'(bus.be_o[7]), 64'h5);
      chk("t4_wdata", 64'(bus.wdata_o[7]), 64'hDEAD_BEEF);
      chk("t4_add", 64'(bus.add_o[7]), 64'h3);
`endif
      tick();
      idle();
      repeat (Lat - 1) tick();
      @(negedge clk_i);
      chk("t4_rvld", 64'(bus.rvld_o), 64'h2);
      tick();

      // Reset one cycle after a grant drops the response and rewinds the pointer
      set_req(2, 32'h0000_000C, 1'b1, 32'h0, 4'hF);
      @(negedge clk_i);
      chk("t5_gnt", 64'(bus.gnt_o), 64'h4);
      tick();
      idle();
      rst_ni = 1'b0;
      @(negedge clk_i);
      chk("t5_rst_gnt", 64'(bus.gnt_o), 64'h0);
      chk("t5_rst_cs", 64'(bus.cs_o), 64'h0);
      chk("t5_rst_rvld", 64'(bus.rvld_o), 64'h0);
      tick();
      rst_ni = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk_i);
         chk($sformatf("t5_no_rvld_%0d", c), 64'(bus.rvld_o), 64'h0);
         tick();
      end
      for (int j = 0; j < NM; j++) set_req(j, (32'(j) << 5) | 32'hC, 1'b1, 32'h0, 4'hF);
      @(negedge clk_i);
      chk("t5_rr_reset", 64'(bus.gnt_o), 64'h1);
      tick();
      idle();
      repeat (Lat + 1) tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
